// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the HI/LO multiply/divide unit.
//   op_t    : 4-bit operation codes driven on muldiv_unit.op
//   state_t : sequencing states of muldiv_unit
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_MUL_LAT = 5;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MULT  = 4'h1,
    OP_MULTU = 4'h2,
    OP_DIV   = 4'h3,
    OP_DIVU  = 4'h4,
    OP_MTHI  = 4'h5,
    OP_MTLO  = 4'h6,
    OP_MADD  = 4'h7,
    OP_MADDU = 4'h8,
    OP_MSUB  = 4'h9,
    OP_MSUBU = 4'hA
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX
  } state_t;

endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: 1-bit/cycle restoring divider on operand magnitudes.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture a/b, take magnitudes (sgn selects signed handling)
//   step       : perform one restoring iteration (WIDTH steps per divide)
//   quo, rem   : sign-corrected quotient/remainder; divide by zero gives
//                quo = all ones, rem = original dividend
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q;
  logic             neg_q, neg_r, bzero;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sh, diff;

  always_comb begin
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    sh    = {rem_q, quo_q[WIDTH-1]};
    diff  = sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bzero <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= mag_a;
      dvs_q <= mag_b;
      a_q   <= a;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      bzero <= (b == '0);
    end else if (step) begin
      // shifted partial remainder is below 2*divisor, so diff's top bit is the borrow
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    quo = bzero ? '1  : (neg_q ? -quo_q : quo_q);
    rem = bzero ? a_q : (neg_r ? -rem_q : rem_q);
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO,
// plus MADD/MADDU/MSUB/MSUBU when MULDIV_MADD_EN is defined).
//   clk, reset : clock, synchronous active-high reset
//   start, op  : operation request (accepted when idle and not flushed)
//   a, b       : rs / rt operands
//   flush      : abort in-flight op, discards any coinciding commit
//   busy       : op in flight, start ignored
//   done       : one-cycle pulse after each HI/LO commit
//   hi, lo     : architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + MUL_LAT + 1);

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic               mul_sgn;
  logic [2*WIDTH-1:0] ae, be, prod, mul_res;
  logic [WIDTH-1:0]   div_q, div_r;

  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ae      = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    be      = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ae * be;
    mul_res = prod;
`ifdef MULDIV_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU) mul_res = {hi, lo} + prod;
    if (op_q == OP_MSUB || op_q == OP_MSUBU) mul_res = {hi, lo} - prod;
`endif
  end

  muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_DIV_PREP),
    .step  (state == ST_DIV_ITER),
    .sgn   (op_q == OP_DIV),
    .a     (a_q),
    .b     (b_q),
    .quo   (div_q),
    .rem   (div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q <= op_t'(op);
              a_q  <= a;
              b_q  <= b;
              case (op)
                OP_MULT, OP_MULTU
`ifdef MULDIV_MADD_EN
                , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                : begin
                  state <= ST_MUL;
                  busy  <= 1'b1;
                  cnt   <= CW'(MUL_LAT - 1);
                end
                OP_DIV, OP_DIVU: begin
                  state <= ST_DIV_PREP;
                  busy  <= 1'b1;
                end
                OP_MTHI: begin
                  hi   <= a;
                  done <= 1'b1;
                end
                OP_MTLO: begin
                  lo   <= a;
                  done <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_DIV_PREP: begin
            state <= ST_DIV_ITER;
            cnt   <= CW'(WIDTH - 1);
          end
          ST_DIV_ITER: begin
            if (cnt == '0) state <= ST_DIV_FIX;
            else           cnt   <= cnt - 1'b1;
          end
          ST_DIV_FIX: begin
            hi    <= div_r;
            lo    <= div_q;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
